phase_stim_gen: RTL and testbench



---
 rtl/phase_stim_gen.sv | 170 +++++++++++++++++
 tb/tb_phase_stim_gen.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/phase_stim_gen.sv
// phase_stim_gen: divided sampling clock plus scripted data bit
// (sync, toggle burst, hold, toggle burst, LFSR random, done).
module phase_stim_gen #(
    parameter int unsigned DIV      = 3,
    parameter int unsigned TOGGLE1  = 14,
    parameter int unsigned HOLD     = 5,
    parameter int unsigned TOGGLE2  = 8,
    parameter int unsigned RAND_LEN = 200,
    parameter logic [15:0] SEED     = 16'hACE1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    output logic       clock_out,
    output logic       a,
    output logic       busy,
    output logic       done,
    output logic [2:0] phase
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_SYNC   = 3'd1;
    localparam logic [2:0] S_BURST1 = 3'd2;
    localparam logic [2:0] S_HOLD   = 3'd3;
    localparam logic [2:0] S_BURST2 = 3'd4;
    localparam logic [2:0] S_RANDOM = 3'd5;
    localparam logic [2:0] S_DONE   = 3'd6;

    localparam int unsigned DW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);

    localparam int unsigned M1 = (TOGGLE1 > HOLD) ? TOGGLE1 : HOLD;
    localparam int unsigned M2 = (TOGGLE2 > RAND_LEN) ? TOGGLE2 : RAND_LEN;
    localparam int unsigned MAXLEN = (M1 > M2) ? M1 : M2;
    localparam int unsigned CW = (MAXLEN > 1) ? $clog2(MAXLEN) : 1;

    // An all-zero LFSR would lock up, so a zero seed becomes 1.
    localparam logic [15:0] SEED_EFF = (SEED == 16'h0000) ? 16'h0001 : SEED;

    logic [2:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [DW-1:0] div_q, div_d;
    logic          clk_q, clk_d;
    logic          a_q, a_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic [15:0]   lfsr_q, lfsr_d;

    logic          div_wrap;
    logic          fall;
    logic          last;
    logic          adv;
    logic          fb;
    logic [2:0]    nxt;

    // First phase at or after 'from' whose length is non-zero;
    // DONE when every remaining phase is skipped.
    function automatic logic [2:0] first_phase(input logic [2:0] from);
        logic [2:0] p;
        p = S_DONE;
        if (from <= S_RANDOM && RAND_LEN != 0) p = S_RANDOM;
        if (from <= S_BURST2 && TOGGLE2 != 0)  p = S_BURST2;
        if (from <= S_HOLD && HOLD != 0)       p = S_HOLD;
        if (from <= S_BURST1 && TOGGLE1 != 0)  p = S_BURST1;
        return p;
    endfunction

    // Counter reload value: phase length minus one, since the
    // counter's zero cycle is itself the last cycle of the phase.
    function automatic logic [CW-1:0] len_m1(input logic [2:0] p);
        logic [CW-1:0] n;
        n = '0;
        unique case (p)
            S_BURST1: n = CW'(TOGGLE1 - 1);
            S_HOLD:   n = CW'(HOLD - 1);
            S_BURST2: n = CW'(TOGGLE2 - 1);
            S_RANDOM: n = CW'(RAND_LEN - 1);
            default:  n = '0;
        endcase
        return n;
    endfunction

    // Free-running divider; a falling toggle is a wrap while high.
    always_comb begin
        div_wrap = (div_q == DIV_LAST);
        div_d    = div_wrap ? '0 : div_q + 1'b1;
        clk_d    = div_wrap ? ~clk_q : clk_q;
        fall     = div_wrap & clk_q;
    end

    // Sequencer: per-phase data update and phase advance.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        lfsr_d  = lfsr_q;
        adv     = 1'b0;
        last    = (cnt_q == '0);
        fb      = lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5];
        nxt     = first_phase(state_q + 3'd1);
        unique case (state_q)
            S_IDLE: begin
                if (start) state_d = S_SYNC;
            end
            S_SYNC: begin
                if (fall) begin
                    a_d = 1'b0;
                    adv = 1'b1;
                end
            end
            S_BURST1, S_BURST2: begin
                a_d   = ~a_q;
                adv   = last;
                cnt_d = cnt_q - 1'b1;
            end
            S_HOLD: begin
                adv   = last;
                cnt_d = cnt_q - 1'b1;
            end
            S_RANDOM: begin
                a_d    = lfsr_q[0];
                lfsr_d = {fb, lfsr_q[15:1]};
                adv    = last;
                cnt_d  = cnt_q - 1'b1;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        if (adv) begin
            state_d = nxt;
            cnt_d   = len_m1(nxt);
        end
        busy_d = (state_d != S_IDLE) && (state_d != S_DONE);
        done_d = (state_d == S_DONE);
    end

    // State registers with synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            div_q   <= '0;
            clk_q   <= 1'b0;
            a_q     <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            lfsr_q  <= SEED_EFF;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            div_q   <= div_d;
            clk_q   <= clk_d;
            a_q     <= a_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            lfsr_q  <= lfsr_d;
        end
    end

    assign clock_out = clk_q;
    assign a         = a_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign phase     = state_q;

endmodule

// File: tb/tb_phase_stim_gen.sv
// tb_phase_stim_gen: randomized scenarios against an
// arithmetic model of the divider and the stimulus script.
module tb_phase_stim_gen;

    localparam int DIV = 3;
    localparam int T1  = 14;
    localparam int HD  = 5;
    localparam int T2  = 8;
    localparam int RL  = 200;
    localparam logic [15:0] SEED = 16'hACE1;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic start = 1'b0;
    logic start_z = 1'b0;

    logic clock_out, a, busy, done;
    logic [2:0] phase;
    logic zclock_out, za, zbusy, zdone;
    logic [2:0] zphase;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    logic [15:0] mlfsr;

    always #5 clk = ~clk;

    phase_stim_gen #(
        .DIV(DIV), .TOGGLE1(T1), .HOLD(HD),
        .TOGGLE2(T2), .RAND_LEN(RL), .SEED(SEED)
    ) u_dut (
        .clk(clk), .reset(reset), .start(start),
        .clock_out(clock_out), .a(a), .busy(busy),
        .done(done), .phase(phase)
    );

    phase_stim_gen #(
        .DIV(1), .TOGGLE1(0), .HOLD(0),
        .TOGGLE2(0), .RAND_LEN(0), .SEED(16'h0000)
    ) u_zero (
        .clk(clk), .reset(reset), .start(start_z),
        .clock_out(zclock_out), .a(za), .busy(zbusy),
        .done(zdone), .phase(zphase)
    );

    initial begin
        #2000000;
        $display("FAIL watchdog expired at cyc=%0d", cyc);
        $fatal(1);
    end

    // clock_out after n edges since reset: high in odd DIV-blocks.
    function automatic logic exp_clk(input int n, input int dv);
        return ((n / dv) % 2) == 1;
    endfunction

    function automatic logic [15:0] lfsr_next(input logic [15:0] l);
        return {l[0] ^ l[2] ^ l[3] ^ l[5], l[15:1]};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        start = 1'b0;
        start_z = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        cyc = 0;
        mlfsr = SEED;
    endtask

    // One full run. With prestarted the run was accepted on the
    // edge just taken; with hold_start start stays high and the
    // run ends right after the following run has been accepted.
    task automatic do_run(input bit hold_start, input bit prestarted,
                          input string tag, output logic [7:0] rand8);
        logic [2:0] ph_q[$];
        logic a_q[$];
        logic cur;
        logic ea;
        logic [2:0] ep;
        int t, es, L, bcnt, dcnt, nr;
        rand8 = '0;
        nr = 0;
        if (!prestarted) begin
            repeat ($urandom_range(0, 2 * DIV)) step();
            start = 1'b1;
            step();
        end
        t = cyc;
        if (!hold_start) start = 1'b0;
        checks++;
        if (phase !== 3'd1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL %s accept phase=%0d busy=%b exp 1/1", tag, phase, busy);
        end
        bcnt = int'(busy);
        dcnt = int'(done);
        es = ((t + 2 * DIV) / (2 * DIV)) * (2 * DIV);
        cur = 1'b0;
        for (int i = 0; i < T1; i++) begin cur = ~cur; a_q.push_back(cur); ph_q.push_back(3'd2); end
        for (int i = 0; i < HD; i++) begin a_q.push_back(cur); ph_q.push_back(3'd3); end
        for (int i = 0; i < T2; i++) begin cur = ~cur; a_q.push_back(cur); ph_q.push_back(3'd4); end
        for (int i = 0; i < RL; i++) begin
            cur = mlfsr[0];
            mlfsr = lfsr_next(mlfsr);
            a_q.push_back(cur);
            ph_q.push_back(3'd5);
        end
        L = a_q.size();
        while (cyc < es) begin
            step();
            bcnt += int'(busy);
            dcnt += int'(done);
            if (cyc < es) begin
                checks++;
                if (phase !== 3'd1) begin
                    errors++;
                    $display("FAIL %s sync phase=%0d exp 1 cyc=%0d", tag, phase, cyc);
                end
            end
        end
        checks++;
        if (a !== 1'b0 || phase !== ((L > 0) ? ph_q[0] : 3'd6)) begin
            errors++;
            $display("FAIL %s sync_exit a=%b phase=%0d cyc=%0d", tag, a, phase, cyc);
        end
        for (int j = 1; j <= L + 1; j++) begin
            step();
            bcnt += int'(busy);
            dcnt += int'(done);
            ea = (L == 0) ? 1'b0 : ((j <= L) ? a_q[j-1] : a_q[L-1]);
            ep = (j < L) ? ph_q[j] : ((j == L) ? 3'd6 : 3'd0);
            checks++;
            if (a !== ea) begin
                errors++;
                $display("FAIL %s a got=%b exp=%b j=%0d", tag, a, ea, j);
            end
            checks++;
            if (phase !== ep || done !== (j == L) || busy !== (j < L)) begin
                errors++;
                $display("FAIL %s ctl phase=%0d done=%b busy=%b exp %0d/%b/%b j=%0d",
                         tag, phase, done, busy, ep, (j == L), (j < L), j);
            end
            checks++;
            if (clock_out !== exp_clk(cyc, DIV)) begin
                errors++;
                $display("FAIL %s clock_out got=%b cyc=%0d", tag, clock_out, cyc);
            end
            if (j <= L && ph_q[j-1] == 3'd5 && nr < 8) begin
                rand8[nr] = a;
                nr++;
            end
        end
        checks++;
        if (bcnt != (es - t) + L) begin
            errors++;
            $display("FAIL %s busy_len got=%0d exp=%0d", tag, bcnt, (es - t) + L);
        end
        checks++;
        if (dcnt != 1) begin
            errors++;
            $display("FAIL %s done_pulses got=%0d exp=1", tag, dcnt);
        end
        if (hold_start) begin
            step();
            checks++;
            if (phase !== 3'd1) begin
                errors++;
                $display("FAIL %s restart phase=%0d exp 1", tag, phase);
            end
        end
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({clock_out, a, busy, done, phase} !== 7'd0) begin
            errors++;
            $display("FAIL reset_vals got=%b exp=0", {clock_out, a, busy, done, phase});
        end
        for (int i = 0; i < 20; i++) begin
            step();
            checks++;
            if (clock_out !== exp_clk(cyc, DIV)) begin
                errors++;
                $display("FAIL idle_clk got=%b cyc=%0d", clock_out, cyc);
            end
            checks++;
            if ({a, busy, done, phase} !== 6'd0) begin
                errors++;
                $display("FAIL idle_outs got=%b exp=0 cyc=%0d", {a, busy, done, phase}, cyc);
            end
        end
    endtask

    task automatic test_full_run();
        logic [7:0] r8;
        do_run(1'b0, 1'b0, "full", r8);
        checks++;
        if (r8 !== 8'hE1) begin
            errors++;
            $display("FAIL first_rand got=%h exp=e1", r8);
        end
    endtask

    task automatic test_lfsr_continue();
        logic [7:0] r8;
        do_run(1'b0, 1'b0, "second", r8);
    endtask

    task automatic test_start_held();
        logic [7:0] r8;
        do_run(1'b1, 1'b0, "held", r8);
        do_run(1'b0, 1'b1, "held_next", r8);
    endtask

    task automatic test_mid_reset();
        logic [7:0] r8;
        int t, es, dcnt;
        dcnt = 0;
        repeat ($urandom_range(0, 2 * DIV)) step();
        start = 1'b1;
        step();
        start = 1'b0;
        t = cyc;
        es = ((t + 2 * DIV) / (2 * DIV)) * (2 * DIV);
        while (cyc < es + 9) begin
            step();
            dcnt += int'(done);
        end
        checks++;
        if (phase !== 3'd2) begin
            errors++;
            $display("FAIL midrst pre phase=%0d exp 2", phase);
        end
        reset = 1'b1;
        @(posedge clk);
        #1;
        dcnt += int'(done);
        checks++;
        if ({clock_out, a, busy, done, phase} !== 7'd0) begin
            errors++;
            $display("FAIL midrst vals got=%b exp=0", {clock_out, a, busy, done, phase});
        end
        reset = 1'b0;
        cyc = 0;
        mlfsr = SEED;
        repeat (2 * DIV) begin
            step();
            dcnt += int'(done);
        end
        checks++;
        if (dcnt != 0 || phase !== 3'd0) begin
            errors++;
            $display("FAIL midrst done_cnt=%0d phase=%0d exp 0/0", dcnt, phase);
        end
        do_run(1'b0, 1'b0, "after_rst", r8);
        checks++;
        if (r8 !== 8'hE1) begin
            errors++;
            $display("FAIL reseed_rand got=%h exp=e1", r8);
        end
    endtask

    task automatic test_zero();
        int t, es;
        do_reset();
        repeat ($urandom_range(0, 3)) begin
            step();
            checks++;
            if (zclock_out !== exp_clk(cyc, 1) || zphase !== 3'd0) begin
                errors++;
                $display("FAIL zero_idle clk=%b phase=%0d cyc=%0d", zclock_out, zphase, cyc);
            end
        end
        start_z = 1'b1;
        step();
        start_z = 1'b0;
        t = cyc;
        es = ((t + 2) / 2) * 2;
        checks++;
        if (zphase !== 3'd1 || zbusy !== 1'b1) begin
            errors++;
            $display("FAIL zero_accept phase=%0d busy=%b exp 1/1", zphase, zbusy);
        end
        while (cyc < es) begin
            step();
            if (cyc < es) begin
                checks++;
                if (zphase !== 3'd1) begin
                    errors++;
                    $display("FAIL zero_sync phase=%0d exp 1", zphase);
                end
            end
        end
        checks++;
        if (zphase !== 3'd6 || zdone !== 1'b1 || zbusy !== 1'b0 || za !== 1'b0) begin
            errors++;
            $display("FAIL zero_done phase=%0d done=%b busy=%b a=%b exp 6/1/0/0",
                     zphase, zdone, zbusy, za);
        end
        checks++;
        if (zclock_out !== 1'b0) begin
            errors++;
            $display("FAIL zero_fall clk=%b exp 0", zclock_out);
        end
        step();
        checks++;
        if (zphase !== 3'd0 || zdone !== 1'b0 || za !== 1'b0) begin
            errors++;
            $display("FAIL zero_idle2 phase=%0d done=%b a=%b exp 0/0/0", zphase, zdone, za);
        end
    endtask

    initial begin
        test_reset();
        test_full_run();
        test_lfsr_continue();
        test_start_held();
        test_mid_reset();
        test_zero();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
